// File: rtl/lock_pkg.sv
// Shared types and constants for the combination-lock digit interface.
package lock_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEND  = 3'd1,
        CHECK = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } sender_state_t;

    localparam int             LOCK_DIGIT_W      = 4;
    localparam int             LOCK_MAX_DIGITS   = 8;
    localparam logic [3:0]     LOCK_IDLE_DIGIT   = 4'hF;
    localparam logic [23:0]    LOCK_DEFAULT_CODE = 24'h335256;

    // pos counts nibbles up from the least significant end of the packed code.
    function automatic logic [LOCK_DIGIT_W-1:0] code_nibble(
        input logic [LOCK_MAX_DIGITS*LOCK_DIGIT_W-1:0] code,
        input int                                      pos
    );
        return code[pos*LOCK_DIGIT_W +: LOCK_DIGIT_W];
    endfunction

endpackage

// File: rtl/lock_code_sender.sv
// Sends the stored code into the lock one digit per cycle and confirms it opened.
// Define LOCK_CODE_SENDER_RETRY_EN to compile in the FLUSH state and retries up to MAX_TRIES.
module lock_code_sender
    import lock_pkg::*;
#(
    parameter logic [LOCK_MAX_DIGITS*LOCK_DIGIT_W-1:0] CODE = {8'h00, LOCK_DEFAULT_CODE},
    parameter int NUM_DIGITS   = 6,
    parameter int CHECK_CYCLES = 2,
    parameter int MAX_TRIES    = 3
)(
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             locked,
    output logic [LOCK_DIGIT_W-1:0]          digit,
    output logic                             busy,
    output logic                             done,
    output logic                             success,
    output logic [$clog2(MAX_TRIES+1)-1:0]   attempts
);

    localparam int IDX_W = 3;
    localparam int CHK_W = $clog2(CHECK_CYCLES + 1);
    localparam int ATT_W = $clog2(MAX_TRIES + 1);

    sender_state_t             state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [CHK_W-1:0]          chk_q, chk_d;
    logic [ATT_W-1:0]          attempts_q, attempts_d;
    logic                      success_q, success_d;
    logic [LOCK_DIGIT_W-1:0]   digit_q, digit_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            chk_q      <= '0;
            attempts_q <= '0;
            success_q  <= 1'b0;
            digit_q    <= LOCK_IDLE_DIGIT;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            chk_q      <= chk_d;
            attempts_q <= attempts_d;
            success_q  <= success_d;
            digit_q    <= digit_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        chk_d      = chk_q;
        attempts_d = attempts_q;
        success_d  = success_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SEND;
                    idx_d      = '0;
                    success_d  = 1'b0;
                    attempts_d = ATT_W'(1);
                end
            end
            SEND: begin
                if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                    state_d = CHECK;
                    chk_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            CHECK: begin
                if (!locked) begin
                    state_d   = DONE;
                    success_d = 1'b1;
                end else if (chk_q == CHK_W'(CHECK_CYCLES - 1)) begin
                    state_d   = DONE;
                    success_d = 1'b0;
`ifdef LOCK_CODE_SENDER_RETRY_EN
                    if (attempts_q < ATT_W'(MAX_TRIES)) begin
                        state_d = FLUSH;
                    end
`endif
                end else begin
                    chk_d = chk_q + CHK_W'(1);
                end
            end
`ifdef LOCK_CODE_SENDER_RETRY_EN
            FLUSH: begin
                state_d    = SEND;
                idx_d      = '0;
                attempts_d = attempts_q + ATT_W'(1);
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are derived from the next state so they line up with it once registered.
        digit_d = LOCK_IDLE_DIGIT;
        if (state_d == SEND) begin
            digit_d = code_nibble(CODE, NUM_DIGITS - 1 - int'(idx_d));
        end
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    assign digit    = digit_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign success  = success_q;
    assign attempts = attempts_q;

endmodule

// File: tb/tb_lock_code_sender.sv
// Self-checking bench for lock_code_sender: two senders (right and wrong code) each drive a behavioural lock.
module tb_lock_code_sender;
    import lock_pkg::*;

    localparam int N = 6;
    localparam int C = 2;
    localparam int M = 3;
    localparam int L = N + C + 1;
`ifdef LOCK_CODE_SENDER_RETRY_EN
    localparam int TRIES = M;
`else
    localparam int TRIES = 1;
`endif
    localparam int GOOD = 32'h00335256;
    localparam int BAD  = 32'h00335257;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic startA = 1'b0, startB = 1'b0;
    logic lockedA, lockedB;
    logic [3:0] digitA, digitB;
    logic busyA, busyB, doneA, doneB, successA, successB;
    logic [1:0] attemptsA, attemptsB;

    int nChecks = 0;
    int nFails = 0;
    bit sucExpA = 1'b0, sucExpB = 1'b0;
    int attExpA = 0, attExpB = 0;

    always #5 clk = ~clk;

    lock_code_sender #(.CODE(32'(GOOD)), .NUM_DIGITS(N), .CHECK_CYCLES(C), .MAX_TRIES(M)) dutA (
        .clk(clk), .reset(reset), .start(startA), .locked(lockedA),
        .digit(digitA), .busy(busyA), .done(doneA), .success(successA), .attempts(attemptsA)
    );

    lock_code_sender #(.CODE(32'(BAD)), .NUM_DIGITS(N), .CHECK_CYCLES(C), .MAX_TRIES(M)) dutB (
        .clk(clk), .reset(reset), .start(startB), .locked(lockedB),
        .digit(digitB), .busy(busyB), .done(doneB), .success(successB), .attempts(attemptsB)
    );

    // Behavioural lock: opens once the last N registered digits equal the real code, stays open until relocked.
    logic [23:0] histA = '1, histB = '1;
    logic openA = 1'b0, openB = 1'b0;
    logic relockA = 1'b0, relockB = 1'b0, preopenA = 1'b0, preopenB = 1'b0;

    always @(posedge clk) begin
        histA <= {histA[19:0], digitA};
        histB <= {histB[19:0], digitB};
        if (relockA) openA <= 1'b0;
        else if (preopenA || {histA[19:0], digitA} == GOOD[23:0]) openA <= 1'b1;
        if (relockB) openB <= 1'b0;
        else if (preopenB || {histB[19:0], digitB} == GOOD[23:0]) openB <= 1'b1;
    end
    assign lockedA = ~openA;
    assign lockedB = ~openB;

    function automatic int nib(input int code, input int off);
        return (code >> (4 * (N - 1 - off))) & 15;
    endfunction

    // Start one request at k=0 and check every cycle until k = doneCycle + tail.
    task automatic runScenario(input string tag, input bit useB, input bit preopen,
                               input bit extraStarts, input int tail);
        bit good;
        int tries, dc, off, code;
        int expDigit, expAtt;
        logic expBusy, expDone, expSuccess;
        logic [3:0] gotDigit;
        logic gotBusy, gotDone, gotSuccess;
        logic [1:0] gotAtt;
        good  = preopen || !useB;
        tries = good ? 1 : TRIES;
        dc    = good ? N + 2 : tries * (N + C) + (tries - 1) + 1;
        code  = useB ? BAD : GOOD;
        for (int k = 0; k <= dc + tail; k++) begin
            @(posedge clk);
            #1;
            gotDigit   = useB ? digitB : digitA;
            gotBusy    = useB ? busyB : busyA;
            gotDone    = useB ? doneB : doneA;
            gotSuccess = useB ? successB : successA;
            gotAtt     = useB ? attemptsB : attemptsA;
            if (k == 0) begin
                expDigit = 15; expBusy = 1'b0; expDone = 1'b0;
                expSuccess = useB ? sucExpB : sucExpA;
                expAtt = useB ? attExpB : attExpA;
            end else if (k < dc) begin
                off = (k - 1) % L;
                expDigit = (off < N) ? nib(code, off) : 15;
                expBusy = 1'b1; expDone = 1'b0; expSuccess = 1'b0;
                expAtt = (k - 1) / L + 1;
            end else begin
                expDigit = 15; expBusy = (k == dc); expDone = (k == dc);
                expSuccess = good; expAtt = tries;
            end
            nChecks++;
            if (int'(gotDigit) !== expDigit) begin
                nFails++;
                $display("[TB] FAIL %s digit k=%0d: got %h expected %h", tag, k, gotDigit, expDigit);
            end
            nChecks++;
            if (gotBusy !== expBusy) begin
                nFails++;
                $display("[TB] FAIL %s busy k=%0d: got %b expected %b", tag, k, gotBusy, expBusy);
            end
            nChecks++;
            if (gotDone !== expDone) begin
                nFails++;
                $display("[TB] FAIL %s done k=%0d: got %b expected %b", tag, k, gotDone, expDone);
            end
            nChecks++;
            if (gotSuccess !== expSuccess) begin
                nFails++;
                $display("[TB] FAIL %s success k=%0d: got %b expected %b", tag, k, gotSuccess, expSuccess);
            end
            nChecks++;
            if (int'(gotAtt) !== expAtt) begin
                nFails++;
                $display("[TB] FAIL %s attempts k=%0d: got %0d expected %0d", tag, k, gotAtt, expAtt);
            end
            if (useB) begin
                startB   = (k == 0) || (extraStarts && k <= dc && $urandom_range(0, 2) == 0);
                relockB  = (k == 0) && !preopen;
                preopenB = (k == 0) && preopen;
            end else begin
                startA   = (k == 0) || (extraStarts && k <= dc && $urandom_range(0, 2) == 0);
                relockA  = (k == 0) && !preopen;
                preopenA = (k == 0) && preopen;
            end
        end
        startA = 1'b0; startB = 1'b0;
        relockA = 1'b0; relockB = 1'b0; preopenA = 1'b0; preopenB = 1'b0;
        if (useB) begin sucExpB = good; attExpB = tries; end
        else      begin sucExpA = good; attExpA = tries; end
    endtask

    task automatic idleGap();
        repeat ($urandom_range(0, 3)) @(posedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        nChecks++;
        if (digitA !== 4'hF || digitB !== 4'hF) begin
            nFails++;
            $display("[TB] FAIL reset digit: got %h/%h expected f", digitA, digitB);
        end
        nChecks++;
        if ({busyA, doneA, successA, busyB, doneB, successB} !== 6'b0) begin
            nFails++;
            $display("[TB] FAIL reset flags: got %b%b%b/%b%b%b expected 0", busyA, doneA, successA, busyB, doneB, successB);
        end
        nChecks++;
        if (attemptsA !== 2'd0 || attemptsB !== 2'd0) begin
            nFails++;
            $display("[TB] FAIL reset attempts: got %0d/%0d expected 0", attemptsA, attemptsB);
        end
        reset = 1'b0;
        sucExpA = 1'b0; sucExpB = 1'b0; attExpA = 0; attExpB = 0;
    endtask

    task automatic test_open_default();
        idleGap();
        runScenario("open", 1'b0, 1'b0, 1'b0, 3);
    endtask

    task automatic test_wrong_code();
        idleGap();
        runScenario("wrong", 1'b1, 1'b0, 1'b0, 3);
    endtask

    task automatic test_start_during_send();
        for (int r = 0; r < 3; r++) begin
            idleGap();
            runScenario("extraStartA", 1'b0, 1'b0, 1'b1, 4);
            idleGap();
            runScenario("extraStartB", 1'b1, 1'b0, 1'b1, 4);
        end
    endtask

    task automatic test_preopen();
        idleGap();
        runScenario("preopenA", 1'b0, 1'b1, 1'b0, 2);
        idleGap();
        runScenario("preopenB", 1'b1, 1'b1, 1'b0, 2);
    endtask

    task automatic test_mid_reset();
        idleGap();
        for (int k = 0; k <= 3; k++) begin
            @(posedge clk);
            #1;
            startA  = (k == 0);
            relockA = (k == 0);
        end
        nChecks++;
        if (digitA !== 4'h5) begin
            nFails++;
            $display("[TB] FAIL midReset pre digit: got %h expected 5", digitA);
        end
        reset = 1'b1;
        #1;
        nChecks++;
        if (digitA !== 4'hF || busyA !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL midReset abort: got digit %h busy %b expected f 0", digitA, busyA);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        sucExpA = 1'b0; sucExpB = 1'b0; attExpA = 0; attExpB = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            nChecks++;
            if (doneA !== 1'b0 || busyA !== 1'b0 || digitA !== 4'hF) begin
                nFails++;
                $display("[TB] FAIL midReset quiet k=%0d: got done %b busy %b digit %h expected 0 0 f", k, doneA, busyA, digitA);
            end
        end
        runScenario("afterReset", 1'b0, 1'b0, 1'b0, 2);
    endtask

    task automatic test_back_to_back();
        idleGap();
        runScenario("b2b1", 1'b0, 1'b0, 1'b0, 0);
        runScenario("b2b2", 1'b0, 1'b0, 1'b0, 0);
        runScenario("b2b3", 1'b1, 1'b0, 1'b0, 0);
        runScenario("b2b4", 1'b1, 1'b0, 1'b0, 3);
    endtask

    initial begin
        $display("[TB] lock_code_sender bench, tries per request %0d", TRIES);
        test_reset();
        test_open_default();
        test_wrong_code();
        test_start_during_send();
        test_preopen();
        test_mid_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
